// File: rtl/muldiv_pkg.sv
// Shared execute-stage types: ALU op codes, multiply/divide op codes,
// the muldiv sequencer state type and op classification helpers.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned WORD_BITS    = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [3:0] {
    MD_MUL   = 4'd0,
    MD_MULW  = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_REM   = 4'd4,
    MD_REMU  = 4'd5,
    MD_DIVW  = 4'd6,
    MD_DIVUW = 4'd7,
    MD_REMW  = 4'd8,
    MD_REMUW = 4'd9
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } muldiv_state_t;

  function automatic logic is_mul_op(input muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULW);
  endfunction

  function automatic logic is_word_op(input muldiv_op_t op);
    return (op == MD_MULW) || (op == MD_DIVW) || (op == MD_DIVUW) ||
           (op == MD_REMW) || (op == MD_REMUW);
  endfunction

  function automatic logic is_signed_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_REM) || (op == MD_DIVW) || (op == MD_REMW);
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return (op == MD_REM) || (op == MD_REMU) || (op == MD_REMW) || (op == MD_REMUW);
  endfunction

  // W-op operands are sign-extended unless the op is an unsigned divide.
  function automatic logic is_signed_ext(input muldiv_op_t op);
    return is_signed_div(op) || (op == MD_MULW);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift/add datapath: operand prep, one shift-add multiply step or
// one restoring divide step per cycle, divide fast-path and sign fixup.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step_mul,
  input  logic            step_div,
  input  logic [3:0]      op,
  input  logic [3:0]      op_q,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            fast_hit,
  output logic [XLEN-1:0] fast_value,
  output logic [XLEN-1:0] fix_value
);

  muldiv_op_t op_in;
  muldiv_op_t op_hold;

  logic [XLEN-1:0] ext1, ext2, mag1, mag2, most_neg, fast_raw;
  logic            word, sdiv, rem, neg1, neg2, div_zero, overflow;

  // reg_a: multiplicand (MUL) or divisor magnitude (DIV)
  // reg_b: multiplier (MUL) or dividend-in / quotient-out shift register (DIV)
  // acc:   product accumulator (MUL) or partial remainder (DIV)
  logic [XLEN-1:0] reg_a, reg_b, acc;
  logic            negq, negr;

  logic [XLEN-1:0] mul_sum;
  logic [XLEN:0]   shifted, diff;
  logic            qbit;

  logic [XLEN-1:0] quot, remd, sel;

  assign op_in   = muldiv_op_t'(op);
  assign op_hold = muldiv_op_t'(op_q);

  // Operand extension, magnitudes and divide fast-path detection for the incoming op.
  always_comb begin
    word = is_word_op(op_in);
    sdiv = is_signed_div(op_in);
    rem  = is_rem(op_in);
    ext1 = src1;
    ext2 = src2;
    if (word) begin
      if (is_signed_ext(op_in)) begin
        ext1 = {{(XLEN-WORD_BITS){src1[WORD_BITS-1]}}, src1[WORD_BITS-1:0]};
        ext2 = {{(XLEN-WORD_BITS){src2[WORD_BITS-1]}}, src2[WORD_BITS-1:0]};
      end else begin
        ext1 = {{(XLEN-WORD_BITS){1'b0}}, src1[WORD_BITS-1:0]};
        ext2 = {{(XLEN-WORD_BITS){1'b0}}, src2[WORD_BITS-1:0]};
      end
    end
    neg1     = sdiv & ext1[XLEN-1];
    neg2     = sdiv & ext2[XLEN-1];
    mag1     = neg1 ? -ext1 : ext1;
    mag2     = neg2 ? -ext2 : ext2;
    most_neg = word ? {{(XLEN-WORD_BITS+1){1'b1}}, {(WORD_BITS-1){1'b0}}}
                    : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (ext2 == '0);
    overflow = sdiv && (ext1 == most_neg) && (ext2 == '1);
    fast_hit = !is_mul_op(op_in) && (div_zero || overflow);
    if (div_zero) fast_raw = rem ? ext1 : '1;
    else          fast_raw = rem ? '0 : ext1;
    fast_value = word ? {{(XLEN-WORD_BITS){fast_raw[WORD_BITS-1]}}, fast_raw[WORD_BITS-1:0]}
                      : fast_raw;
  end

  // One multiply or restoring-divide step from the current register contents.
  always_comb begin
    mul_sum = acc + (reg_b[0] ? reg_a : '0);
    shifted = {acc, reg_b[XLEN-1]};
    diff    = shifted - {1'b0, reg_a};
    qbit    = ~diff[XLEN];
  end

  // Sign correction, quotient/remainder select and W-op sign extension.
  always_comb begin
    quot = negq ? -reg_b : reg_b;
    remd = negr ? -acc : acc;
    if (is_mul_op(op_hold))   sel = acc;
    else if (is_rem(op_hold)) sel = remd;
    else                      sel = quot;
    fix_value = is_word_op(op_hold)
              ? {{(XLEN-WORD_BITS){sel[WORD_BITS-1]}}, sel[WORD_BITS-1:0]}
              : sel;
  end

  // Operand registers, loaded on accept and advanced once per MUL/DIV cycle.
  // W divides pre-shift the dividend to the top so 32 steps consume it fully.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_a <= '0;
      reg_b <= '0;
      acc   <= '0;
      negq  <= 1'b0;
      negr  <= 1'b0;
    end else if (load) begin
      acc  <= '0;
      negq <= neg1 ^ neg2;
      negr <= neg1;
      if (is_mul_op(op_in)) begin
        reg_a <= ext1;
        reg_b <= ext2;
      end else begin
        reg_a <= mag2;
        reg_b <= word ? (mag1 << WORD_BITS) : mag1;
      end
    end else if (step_mul) begin
      acc   <= mul_sum;
      reg_a <= reg_a << 1;
      reg_b <= reg_b >> 1;
    end else if (step_div) begin
      acc   <= qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      reg_b <= {reg_b[XLEN-2:0], qbit};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV64M multiply/divide engine: start/ack handshake, control FSM
// and step counter; arithmetic lives in muldiv_datapath.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  input  logic            ack,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_WORD = CW'(WORD_BITS - 1);

  muldiv_state_t   state;
  logic [CW-1:0]   counter;
  logic [3:0]      op_q;
  muldiv_op_t      op_in;
  logic            accept;
  logic            fast_hit;
  logic [XLEN-1:0] fast_value, fix_value;

  assign op_in  = muldiv_op_t'(op);
  assign accept = (state == ST_IDLE) && start && !flush;
  assign busy   = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIXUP);
  assign done   = (state == ST_DONE);

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .step_mul   (state == ST_MUL),
    .step_div   (state == ST_DIV),
    .op         (op),
    .op_q       (op_q),
    .src1       (src1),
    .src2       (src2),
    .fast_hit   (fast_hit),
    .fast_value (fast_value),
    .fix_value  (fix_value)
  );

  // Control FSM, step counter and result register; flush overrides every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      op_q    <= '0;
      result  <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            counter <= is_word_op(op_in) ? CNT_WORD : CNT_FULL;
            if (fast_hit) begin
              result <= fast_value;
              state  <= ST_DONE;
            end else if (is_mul_op(op_in)) begin
              state <= ST_MUL;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (counter == '0) state <= ST_FIXUP;
          else               counter <= counter - CW'(1);
        end
        ST_FIXUP: begin
          result <= fix_value;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          if (ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vectors, randomized ops
// against an arithmetic reference model, flush, hold, and async reset.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush, ack;
  logic [3:0]  op;
  logic [63:0] src1, src2;
  logic        busy, done;
  logic [63:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .flush  (flush),
    .ack    (ack),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      tests++;
      if (busy === 1'b1 && done === 1'b1) begin
        fails++;
        $display("FAIL busy_done_exclusive: busy=%b done=%b both high", busy, done);
      end
    end
  end

  function automatic logic is_w(input logic [3:0] o);
    return (o == MD_MULW) || (o == MD_DIVW) || (o == MD_DIVUW) ||
           (o == MD_REMW) || (o == MD_REMUW);
  endfunction

  // RISC-V M-extension semantics with plain arithmetic.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    r = '0; r32 = '0;
    case (o)
      MD_MUL:   r = a * b;
      MD_MULW:  r32 = a32 * b32;
      MD_DIV:   if (b == 0) r = '1;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                else r = sa / sb;
      MD_DIVU:  r = (b == 0) ? '1 : a / b;
      MD_REM:   if (b == 0) r = a;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                else r = sa % sb;
      MD_REMU:  r = (b == 0) ? a : a % b;
      MD_DIVW:  if (b32 == 0) r32 = '1;
                else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                else r32 = sa32 / sb32;
      MD_DIVUW: r32 = (b32 == 0) ? '1 : a32 / b32;
      MD_REMW:  if (b32 == 0) r32 = a32;
                else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                else r32 = sa32 % sb32;
      MD_REMUW: r32 = (b32 == 0) ? a32 : a32 % b32;
      default:  r = '0;
    endcase
    if (is_w(o)) r = {{32{r32[31]}}, r32};
    return r;
  endfunction

  // Cycles from the accept edge (counted as 1) until done is seen.
  function automatic int exp_lat(input logic [3:0] o, input logic [63:0] a,
                                 input logic [63:0] b);
    logic sgn;
    if (o == MD_MUL)  return 66;
    if (o == MD_MULW) return 34;
    sgn = (o == MD_DIV) || (o == MD_REM) || (o == MD_DIVW) || (o == MD_REMW);
    if (is_w(o)) begin
      if (b[31:0] == 0) return 1;
      if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 34;
    end
    if (b == 0) return 1;
    if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 66;
  endfunction

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'($urandom_range(0, 20));
      4: v = 64'h0000_0000_8000_0000;
      5: begin v[31:0] = $urandom; v[63:32] = {32{v[31]}}; end
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Drive one request from IDLE and wait (bounded) for done.
  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    op = o; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; flush = 0; ack = 0; op = '0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0)  begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (result !== '0)  begin fails++; $display("FAIL reset_result: got %h want 0", result); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [63:0] a, b, exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    logic [63:0] res;
    int lat;
    v[0] = '{MD_MUL,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
    v[1] = '{MD_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    v[2] = '{MD_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    v[3] = '{MD_DIVU,  64'd100, 64'd7, 64'd14, 66};
    v[4] = '{MD_REMU,  64'd100, 64'd7, 64'd2, 66};
    v[5] = '{MD_DIVU,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    v[6] = '{MD_REMW,  64'h1_0000_0005, 64'd0, 64'd5, 1};
    v[7] = '{MD_DIVW,  64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    v[8] = '{MD_REMW,  64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
    v[9] = '{MD_MULW,  64'h1_0000, 64'h8000, 64'hFFFF_FFFF_8000_0000, 34};
    for (int i = 0; i < 10; i++) begin
      issue(v[i].o, v[i].a, v[i].b, res, lat);
      tests++;
      if (res !== v[i].exp) begin
        fails++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, v[i].exp);
      end
      tests++;
      if (lat != v[i].lat) begin
        fails++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, v[i].lat);
      end
      do_ack();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL directed_ack_idle[%0d]: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  // Back-to-back random ops: each start issued the cycle after ack returns to IDLE.
  task automatic test_random();
    logic [63:0] a, b, res, exp;
    logic [3:0]  o;
    int lat, el;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 9));
      a = pick_operand();
      b = pick_operand();
      exp = model(o, a, b);
      el = exp_lat(o, a, b);
      issue(o, a, b, res, lat);
      tests++;
      if (res !== exp) begin
        fails++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, a, b, res, exp);
      end
      tests++;
      if (lat != el) begin
        fails++; $display("FAIL random_latency[%0d] op=%0d: got %0d want %0d", i, o, lat, el);
      end
      do_ack();
    end
  endtask

  task automatic test_flush();
    logic [63:0] prev, res;
    int lat;
    prev = result;
    op = MD_DIV; src1 = 64'd123456789; src2 = 64'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL flush_done: got %b want 0", done); end
    tests++; if (result !== prev) begin fails++; $display("FAIL flush_result_kept: got %h want %h", result, prev); end
    repeat (3) begin @(posedge clk); #1; end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL flush_no_done: got %b want 0", done); end
    flush = 1'b1; start = 1'b1; op = MD_MUL; src1 = 64'd9; src2 = 64'd9;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_over_start: busy got %b want 0", busy); end
    issue(MD_REMU, 64'd1000, 64'd33, res, lat);
    tests++; if (res !== 64'd10) begin fails++; $display("FAIL flush_then_start: got %h want %h", res, 64'd10); end
    do_ack();
  endtask

  task automatic test_hold_ignore();
    logic [63:0] first, exp;
    int lat;
    exp = model(MD_DIVU, 64'd1_000_000_007, 64'd97);
    op = MD_DIVU; src1 = 64'd1_000_000_007; src2 = 64'd97; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    op = MD_MUL; src1 = 64'd11; src2 = 64'd13;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; lat++; end
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    tests++; if (lat != 66) begin fails++; $display("FAIL ignore_latency: got %0d want 66", lat); end
    first = result;
    tests++; if (first !== exp) begin fails++; $display("FAIL ignore_start_busy: got %h want %h", first, exp); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b1 || result !== exp) begin
        fails++; $display("FAIL hold_no_ack[%0d]: done=%b result=%h want 1 %h", i, done, result, exp);
      end
    end
    do_ack();
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int lat;
    issue(MD_MUL, 64'd3, 64'd5, res, lat);
    do_ack();
    op = MD_DIV; src1 = 64'd999; src2 = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL async_reset_done: got %b want 0", done); end
    tests++; if (result !== '0) begin fails++; $display("FAIL async_reset_result: got %h want 0", result); end
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    issue(MD_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, res, lat);
    tests++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFF2) begin
      fails++; $display("FAIL after_reset_op: got %h want %h", res, 64'hFFFF_FFFF_FFFF_FFF2);
    end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_hold_ignore();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
